// File: rtl/sivers_gpio_pkg.sv
// Shared constants, types and helpers for the SIVERS GPIO AXI4-Lite register bank.
// Contents: register index constants, response code, word/strobe widths,
// write-commit payload struct and the byte-strobe merge helper.
package sivers_gpio_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned IDX_W    = 2;

  localparam logic [IDX_W-1:0] REG_CTRL0 = 2'd0;
  localparam logic [IDX_W-1:0] REG_CTRL1 = 2'd1;
  localparam logic [IDX_W-1:0] REG_CTRL2 = 2'd2;
  localparam logic [IDX_W-1:0] REG_CTRL3 = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef logic [DATA_W-1:0] reg_word_t;

  // Write transaction as seen at the commit point
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    reg_word_t         data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Replace only the strobed bytes of the current word
  function automatic reg_word_t apply_strb(input reg_word_t cur, input reg_word_t nxt,
                                           input logic [STRB_W-1:0] strb);
    reg_word_t res;
    res = cur;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sivers_gpio_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the GPIO register bank.
// Modports: master (drives requests, takes responses), slave (the reverse).
interface sivers_gpio_axil_slave_if #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]             wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/sivers_gpio_wr_buf.sv
// One-entry AW and W capture buffers for the GPIO register bank write path.
// Ports: clk/rst_n; aw_hs/aw_idx and w_hs/w_data/w_strb from the channel
// handshakes; aw_held/w_held flags; commit_c strobe with its payload commit_req_c.
module sivers_gpio_wr_buf
  import sivers_gpio_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aw_hs,
  input  logic [IDX_W-1:0]  aw_idx,
  input  logic              w_hs,
  input  reg_word_t         w_data,
  input  logic [STRB_W-1:0] w_strb,
  output logic              aw_held,
  output logic              w_held,
  output logic              commit_c,
  output wr_req_t           commit_req_c
);

  logic [IDX_W-1:0]  aw_idx_q;
  reg_word_t         w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  // Commit as soon as both halves are available, buffered or arriving now
  always_comb begin
    commit_c          = (aw_held || aw_hs) && (w_held || w_hs);
    commit_req_c.idx  = aw_held ? aw_idx_q : aw_idx;
    commit_req_c.data = w_held ? w_data_q : w_data;
    commit_req_c.strb = w_held ? w_strb_q : w_strb;
  end

  // Capture whichever channel arrives first; flags clear on commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit_c) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_idx;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
    end
  end

endmodule

// File: rtl/sivers_gpio_axil_slave.sv
// AXI4-Lite slave holding four 32-bit SIVERS GPIO control registers (0x0..0xC).
// Ports: ACLK, ARESETN (async active-low), s_axi (slave modport of the bus
// bundle), gpio_reg_o = {reg3,reg2,reg1,reg0}.
// Optional: define SIVERS_GPIO_UPD_PULSE_EN to add reg_upd_o[3:0], a one-cycle
// per-register pulse aligned with bvalid rising after a strobed commit.
module sivers_gpio_axil_slave
  import sivers_gpio_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RST_VAL          = 32'h0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  sivers_gpio_axil_slave_if.slave      s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   gpio_reg_o
`ifdef SIVERS_GPIO_UPD_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]          reg_upd_o
`endif
);

  logic                          ready_en;
  logic                          bvalid_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  reg_word_t                     regs [NUM_REGS];
  logic                          aw_held, w_held;
  logic                          awready_c, wready_c, arready_c;
  logic                          aw_hs, w_hs, ar_hs;
  logic                          commit_c;
  wr_req_t                       commit_req_c;
  logic                          unused_c;

  assign awready_c = ready_en && !aw_held && !bvalid_q;
  assign wready_c  = ready_en && !w_held && !bvalid_q;
  assign arready_c = ready_en && !rvalid_q;
  assign aw_hs     = s_axi.awvalid && awready_c;
  assign w_hs      = s_axi.wvalid && wready_c;
  assign ar_hs     = s_axi.arvalid && arready_c;

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.arready = arready_c;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = AXI_RESP_OKAY;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = AXI_RESP_OKAY;

  // Protection bits and byte-lane address bits carry no meaning here
  assign unused_c = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  sivers_gpio_wr_buf u_wr_buf (
    .clk          (ACLK),
    .rst_n        (ARESETN),
    .aw_hs        (aw_hs),
    .aw_idx       (s_axi.awaddr[3:2]),
    .w_hs         (w_hs),
    .w_data       (reg_word_t'(s_axi.wdata)),
    .w_strb       (s_axi.wstrb),
    .aw_held      (aw_held),
    .w_held       (w_held),
    .commit_c     (commit_c),
    .commit_req_c (commit_req_c)
  );

  // Keeps all readies low for the first cycle after reset release
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Register array with byte-strobed update
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= C_RST_VAL;
    end else if (commit_c) begin
      regs[commit_req_c.idx] <= apply_strb(regs[commit_req_c.idx], commit_req_c.data,
                                           commit_req_c.strb);
    end
  end

  // Write response: raised after commit, held until bready
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)      bvalid_q <= 1'b0;
    else if (commit_c) bvalid_q <= 1'b1;
    else if (s_axi.bready) bvalid_q <= 1'b0;
  end

  // Read path: data sampled at AR handshake, so a same-cycle commit is not visible
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= C_S_AXI_DATA_WIDTH'(regs[s_axi.araddr[3:2]]);
    end else if (s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign gpio_reg_o = {regs[REG_CTRL3], regs[REG_CTRL2], regs[REG_CTRL1], regs[REG_CTRL0]};

`ifdef SIVERS_GPIO_UPD_PULSE_EN
  // Pulse lands on the same edge that raises bvalid
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) reg_upd_o <= '0;
    else if (commit_c && (|commit_req_c.strb))
      reg_upd_o <= NUM_REGS'(1) << commit_req_c.idx;
    else
      reg_upd_o <= '0;
  end
`endif

endmodule

// File: doc/sivers_gpio_axil_slave.md
Name: sivers_gpio_axil_slave

Overview:
AXI4-Lite responder (slave end) for the SIVERS GPIO register bank, driven by the PS/VIP master on the S00_AXI port. Holds four 32-bit read/write control registers at byte offsets 0x0, 0x4, 0x8 and 0xC. Register contents drive the SIVERS radio control lines.
Accepts the AW and W channels independently, buffers whichever arrives first, commits the write with byte strobes, and returns one response per transaction. Reads are single-beat with backpressure hold.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] ignored
C_RST_VAL, 32'h0, reset value of all four registers

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  always 2'b00 (OKAY)
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00 (OKAY)
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
gpio_reg_o  out  128  {reg3,reg2,reg1,reg0}, registered

Behaviour:
- Reset (ARESETN=0, asynchronous): all registers = C_RST_VAL; awready, wready, arready and rvalid = 0; bvalid = 0; rdata = 0; AW/W buffers cleared.
- Reset state is held in the first cycle after deassertion. Readies assert from the second cycle onward.
- Write path:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - On handshake, the address/data (and strobes) are captured into a one-entry buffer; the corresponding held flag is set.
  - Commit occurs in the cycle where both are held, or arrive together, or one is held and the other arrives. The register is updated byte-wise per wstrb.
  - bvalid rises the cycle after commit; held flags clear at the same edge.
  - bvalid stays high until bready; no new AW/W is accepted while bvalid=1.
  - Minimum write latency: AW+W in cycle N -> register updated at edge N+1, bvalid=1 in cycle N+1.
- Read path:
  - arready = !rvalid.
  - On AR handshake in cycle N: rdata = reg[araddr[3:2]] and rvalid=1 in cycle N+1.
  - rdata/rvalid are held stable until rready. A read accepted alongside a same-address write commit in the same cycle returns the pre-write value.
- wstrb = 0: handshake completes and bresp returned; no register change.
- Address bits above [3:2] or below 2 are ignored (aliasing, no SLVERR).
- Read and write channels are fully independent; concurrent operation allowed.
- Reset mid-transaction: all handshakes abort; the master must reissue.

Optional Feature:
SIVERS_GPIO_UPD_PULSE_EN
- Defined: extra outputs reg_upd_o[3:0]. One-cycle pulse on bit k coincident with bvalid's rising edge when register k was committed with nonzero wstrb.
- Not defined: ports absent, no extra logic.

Decomposition:
- Package sivers_gpio_pkg: register index constants (REG_CTRL0..REG_CTRL3 = 0..3), AXI_RESP_OKAY = 2'b00, NUM_REGS = 4, register word typedef.
- One sub-module sivers_gpio_wr_buf: AW/W one-entry capture buffers with held flags and commit strobe.
- Read path and register array stay in the top.

Test Plan:
- Reset, then AW+W simultaneous to 0x0/0x4/0x8/0xC with data 1,2,3,4 and wstrb=F -> four OKAY bresps; reads return 1,2,3,4; gpio_reg_o = 0x00000004_00000003_00000002_00000001.
- W (0xDEADBEEF) issued 3 cycles before AW (0x8) -> wready drops after W capture; single bresp after AW; reg2=0xDEADBEEF.
- Write 0xAABBCCDD to 0x4, then wstrb=4'b0010 with data 0x00001100 -> read 0x4 returns 0xAABB11DD.
- Read 0xC with rready held low 5 cycles -> rvalid and rdata=0x4 stable; arready low throughout; one beat only.
- bready held low 4 cycles after a write -> awready/wready stay low; second write accepted only after B handshake.
- Assert ARESETN=0 mid-write (AW held, W pending) -> all regs = C_RST_VAL, bvalid=0. Post-reset read of 0x0 returns 0.
